reg_readback_serializer: RTL

//  Reader side of the register storage: snapshots a WIDTH-bit group of register

---
 rtl/reg_readback_serializer.sv | 62 ++++++
 1 files changed

// File: rtl/reg_readback_serializer.sv
// reg_readback_serializer: captures a group of register q bits and streams them out
// one bit per valid/ready transfer, with busy/done status for the readback consumer.
module reg_readback_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_snap_req,
    input  logic [WIDTH-1:0] i_par_in,
    input  logic             i_ser_ready,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_ser_last,
    output logic             o_snap_busy,
    output logic             o_snap_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [CW-1:0]    r_cnt;
    logic             w_shift;
    logic             w_last;
    logic [CW-1:0]    w_idx;

    assign w_shift = r_state == SHIFT;
    assign w_last  = r_cnt == LAST;
    assign w_idx   = MSB_FIRST ? LAST - r_cnt : r_cnt;

    // Outputs decode registered state only, so none depends on an input this cycle.
    assign o_ser_valid = w_shift;
    assign o_ser_out   = w_shift & r_shadow[w_idx];
    assign o_ser_last  = w_shift & w_last;
    assign o_snap_busy = r_state != IDLE;
    assign o_snap_done = r_state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_snap_req) begin
                    r_shadow <= i_par_in;
                    r_cnt    <= '0;
                    r_state  <= SHIFT;
                end
                SHIFT: if (i_ser_ready) begin
                    if (w_last) r_state <= DONE;
                    else r_cnt <= r_cnt + 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
